// File: rtl/dl_fetch_engine_if.sv
// dl_fetch_engine_if
//   Groups the two buses of the display-list fetch engine.
//   Memory read port (one outstanding request):
//     MEM_REQ  / MEM_ADDR    engine -> memory, held until the ack cycle
//     MEM_ACK  / MEM_DATA    memory -> engine, data valid in the ack cycle
//   Line RAM writer load port:
//     INPUT_ADDR, PALETTE, WM with one-cycle strobes INPUT_W, PALETTE_W, WM_W
//     PIXELS with one-cycle strobe PIXELS_W
//   master = fetch engine side, slave = memory / line RAM side.
interface dl_fetch_engine_if;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [7:0]  MEM_DATA;
    logic [7:0]  INPUT_ADDR;
    logic [2:0]  PALETTE;
    logic        WM;
    logic        INPUT_W;
    logic        PALETTE_W;
    logic        WM_W;
    logic [7:0]  PIXELS;
    logic        PIXELS_W;

    modport master (
        output MEM_REQ, MEM_ADDR,
        input  MEM_ACK, MEM_DATA,
        output INPUT_ADDR, PALETTE, WM, INPUT_W, PALETTE_W, WM_W,
        output PIXELS, PIXELS_W
    );

    modport slave (
        input  MEM_REQ, MEM_ADDR,
        output MEM_ACK, MEM_DATA,
        input  INPUT_ADDR, PALETTE, WM, INPUT_W, PALETTE_W, WM_W,
        input  PIXELS, PIXELS_W
    );
endinterface

// File: rtl/dl_fetch_engine.sv
// dl_fetch_engine
//   Maria display-list DMA stage for one zone. Walks the display list,
//   decodes 4-byte and 5-byte (extended) headers, fetches graphics bytes
//   (direct or indirect/character mode) and feeds the line RAM writer.
// Ports:
//   SYSCLK, RESET      clock, asynchronous active-high reset
//   DL_START, DL_ADDR  start pulse and list base address (ignored while busy)
//   OFFSET             zone line offset added to the graphics high byte
//   CHARBASE, CWIDTH   character base high byte and 1/2 bytes per character
//   BUSY, DONE         busy level and one-cycle end-of-list pulse
//   bus                memory read port and line RAM load port (master side)
module dl_fetch_engine (
    input  logic              SYSCLK,
    input  logic              RESET,
    input  logic              DL_START,
    input  logic [15:0]       DL_ADDR,
    input  logic [3:0]        OFFSET,
    input  logic [7:0]        CHARBASE,
    input  logic              CWIDTH,
    output logic              BUSY,
    output logic              DONE,
    dl_fetch_engine_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,    // header bytes b0..b3 (b4 for extended)
        S_SETUP,  // one-cycle line RAM header load
        S_GFX,    // direct graphics fetch
        S_PTR,    // indirect: character pointer fetch
        S_CHR,    // indirect: character graphics fetch(es)
        S_END
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] dlp_reg, dlp_next;
    logic [2:0]  hidx_reg, hidx_next;
    logic [7:0]  b0_reg, b0_next;
    logic [7:0]  b1_reg, b1_next;
    logic [7:0]  b2_reg, b2_next;
    logic [7:0]  b3_reg, b3_next;
    logic [7:0]  low_reg, low_next;
    logic [7:0]  high_reg, high_next;
    logic [4:0]  width_reg, width_next;
    logic        ind_reg, ind_next;
    logic [4:0]  idx_reg, idx_next;
    logic [7:0]  ptr_reg, ptr_next;
    logic        csub_reg, csub_next;
    logic        req_reg, req_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  inaddr_reg, inaddr_next;
    logic [2:0]  pal_reg, pal_next;
    logic        wm_reg, wm_next;
    logic [7:0]  pix_reg, pix_next;
    logic        pixw_reg, pixw_next;

    logic        ack;
    logic        last_byte;
    logic        hdr_term;
    logic        hdr_ext;
    logic [15:0] gfx_addr;
    logic [15:0] src_addr;
    logic [15:0] chr_addr;

    // An ack only counts while our own request is outstanding.
    assign ack = bus.MEM_ACK && req_reg;

    // Byte count is (32 - width) mod 32 with 0 meaning 32, so the index of
    // the last byte is 31 - width, i.e. the bitwise complement of width.
    assign last_byte = (idx_reg == ~width_reg);

    assign hdr_term = (b1_reg[6:0] == 7'd0);
    assign hdr_ext  = (b1_reg[4:0] == 5'd0) && b1_reg[6];

    // The 8-bit high-byte sums wrap on their own before the 16-bit add.
    assign gfx_addr = {high_reg + {4'd0, OFFSET}, low_reg} + {11'd0, idx_reg};
    assign src_addr = {high_reg, low_reg} + {11'd0, idx_reg};
    assign chr_addr = {CHARBASE + {4'd0, OFFSET}, ptr_reg} + {15'd0, csub_reg};

    // State and datapath registers
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= S_IDLE;
            dlp_reg    <= 16'd0;
            hidx_reg   <= 3'd0;
            b0_reg     <= 8'd0;
            b1_reg     <= 8'd0;
            b2_reg     <= 8'd0;
            b3_reg     <= 8'd0;
            low_reg    <= 8'd0;
            high_reg   <= 8'd0;
            width_reg  <= 5'd0;
            ind_reg    <= 1'b0;
            idx_reg    <= 5'd0;
            ptr_reg    <= 8'd0;
            csub_reg   <= 1'b0;
            req_reg    <= 1'b0;
            addr_reg   <= 16'd0;
            inaddr_reg <= 8'd0;
            pal_reg    <= 3'd0;
            wm_reg     <= 1'b0;
            pix_reg    <= 8'd0;
            pixw_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dlp_reg    <= dlp_next;
            hidx_reg   <= hidx_next;
            b0_reg     <= b0_next;
            b1_reg     <= b1_next;
            b2_reg     <= b2_next;
            b3_reg     <= b3_next;
            low_reg    <= low_next;
            high_reg   <= high_next;
            width_reg  <= width_next;
            ind_reg    <= ind_next;
            idx_reg    <= idx_next;
            ptr_reg    <= ptr_next;
            csub_reg   <= csub_next;
            req_reg    <= req_next;
            addr_reg   <= addr_next;
            inaddr_reg <= inaddr_next;
            pal_reg    <= pal_next;
            wm_reg     <= wm_next;
            pix_reg    <= pix_next;
            pixw_reg   <= pixw_next;
        end
    end

    // Next-state and datapath logic. Every fetch state works the same way:
    // a cycle with no request outstanding issues the next read, then the
    // request is held until its ack, after which it drops for a cycle.
    always_comb begin
        state_next  = state_reg;
        dlp_next    = dlp_reg;
        hidx_next   = hidx_reg;
        b0_next     = b0_reg;
        b1_next     = b1_reg;
        b2_next     = b2_reg;
        b3_next     = b3_reg;
        low_next    = low_reg;
        high_next   = high_reg;
        width_next  = width_reg;
        ind_next    = ind_reg;
        idx_next    = idx_reg;
        ptr_next    = ptr_reg;
        csub_next   = csub_reg;
        req_next    = req_reg;
        addr_next   = addr_reg;
        inaddr_next = inaddr_reg;
        pal_next    = pal_reg;
        wm_next     = wm_reg;
        pix_next    = pix_reg;
        pixw_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (DL_START) begin
                    dlp_next   = DL_ADDR;
                    hidx_next  = 3'd0;
                    state_next = S_HDR;
                end
            end

            S_HDR: begin
                if (!req_reg) begin
                    req_next  = 1'b1;
                    addr_next = dlp_reg + {13'd0, hidx_reg};
                end else if (ack) begin
                    req_next = 1'b0;
                    case (hidx_reg)
                        3'd0: begin
                            b0_next   = bus.MEM_DATA;
                            hidx_next = 3'd1;
                        end
                        3'd1: begin
                            b1_next   = bus.MEM_DATA;
                            hidx_next = 3'd2;
                        end
                        3'd2: begin
                            b2_next   = bus.MEM_DATA;
                            hidx_next = 3'd3;
                        end
                        3'd3: begin
                            b3_next = bus.MEM_DATA;
                            if (hdr_term) begin
                                state_next = S_END;
                            end else if (hdr_ext) begin
                                hidx_next = 3'd4;
                            end else begin
                                low_next    = b0_reg;
                                high_next   = b2_reg;
                                width_next  = b1_reg[4:0];
                                ind_next    = 1'b0;
                                inaddr_next = bus.MEM_DATA;
                                pal_next    = b1_reg[7:5];
                                wm_next     = 1'b0;
                                dlp_next    = dlp_reg + 16'd4;
                                state_next  = S_SETUP;
                            end
                        end
                        default: begin
                            // Fifth byte of an extended header carries hpos.
                            low_next    = b0_reg;
                            high_next   = b2_reg;
                            width_next  = b3_reg[4:0];
                            ind_next    = b1_reg[5];
                            inaddr_next = bus.MEM_DATA;
                            pal_next    = b3_reg[7:5];
                            wm_next     = b1_reg[7];
                            dlp_next    = dlp_reg + 16'd5;
                            state_next  = S_SETUP;
                        end
                    endcase
                end
            end

            S_SETUP: begin
                idx_next   = 5'd0;
                csub_next  = 1'b0;
                state_next = ind_reg ? S_PTR : S_GFX;
            end

            S_GFX: begin
                if (!req_reg) begin
                    req_next  = 1'b1;
                    addr_next = gfx_addr;
                end else if (ack) begin
                    req_next  = 1'b0;
                    pix_next  = bus.MEM_DATA;
                    pixw_next = 1'b1;
                    if (last_byte) begin
                        hidx_next  = 3'd0;
                        state_next = S_HDR;
                    end else begin
                        idx_next = idx_reg + 5'd1;
                    end
                end
            end

            S_PTR: begin
                if (!req_reg) begin
                    req_next  = 1'b1;
                    addr_next = src_addr;
                end else if (ack) begin
                    req_next   = 1'b0;
                    ptr_next   = bus.MEM_DATA;
                    csub_next  = 1'b0;
                    state_next = S_CHR;
                end
            end

            S_CHR: begin
                if (!req_reg) begin
                    req_next  = 1'b1;
                    addr_next = chr_addr;
                end else if (ack) begin
                    req_next  = 1'b0;
                    pix_next  = bus.MEM_DATA;
                    pixw_next = 1'b1;
                    if (CWIDTH && !csub_reg) begin
                        csub_next = 1'b1;
                    end else if (last_byte) begin
                        hidx_next  = 3'd0;
                        state_next = S_HDR;
                    end else begin
                        idx_next   = idx_reg + 5'd1;
                        state_next = S_PTR;
                    end
                end
            end

            S_END: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.MEM_REQ    = req_reg;
        bus.MEM_ADDR   = addr_reg;
        bus.INPUT_ADDR = inaddr_reg;
        bus.PALETTE    = pal_reg;
        bus.WM         = wm_reg;
        bus.INPUT_W    = (state_reg == S_SETUP);
        bus.PALETTE_W  = (state_reg == S_SETUP);
        bus.WM_W       = (state_reg == S_SETUP);
        bus.PIXELS     = pix_reg;
        bus.PIXELS_W   = pixw_reg;
        DONE           = (state_reg == S_END);
        BUSY           = (state_reg != S_IDLE) && (state_reg != S_END);
    end
endmodule
